// File: rtl/demux_1to4_buf.sv
// ---------------------------------------------------------------------------
// demux_1to4_buf
//
// Purpose:
//   1-to-4 demultiplexer with a one-entry holding register per output
//   channel. A single valid/ready input stream is steered to channel
//   A/B/C/D. Each channel has its own valid/ready handshake, so one
//   stalled consumer only blocks words that are headed for it.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   In_Data    in   [WIDTH]  input payload
//   In_Valid   in   input payload valid
//   In_Ready   out  input can be accepted this cycle (combinational)
//   Sel        in   [2] destination: 0=A 1=B 2=C 3=D
//   Out_A..D   out  [WIDTH] per-channel holding registers
//   Out_Valid  out  [4] per-channel valid (bit0=A .. bit3=D)
//   Out_Ready  in   [4] per-channel consumer ready (same order)
//   Xfer_Cnt   out  [CNT_W] accepted-transfer counter, wraps to 0
//   Seq_Ptr    out  [2] round-robin destination pointer
//                   (present only with DEMUX_AUTO_SEQ_EN)
//
// Build option:
//   DEMUX_AUTO_SEQ_EN - when defined, Sel is ignored and destinations
//   rotate A,B,C,D,A,... through an internal pointer that advances on
//   every accepted word. A full destination stalls the stream; the
//   pointer never skips a channel.
// ---------------------------------------------------------------------------

// One output channel: holding register plus its valid flag.
module demux_1to4_buf_chan #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_pop;

  assign w_pop = r_valid & i_ready;

  // A load wins over a pop: a word arriving while the old one drains
  // keeps valid high, so back-to-back traffic has no bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

module demux_1to4_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       Sel,
  output logic [WIDTH-1:0] Out_A,
  output logic [WIDTH-1:0] Out_B,
  output logic [WIDTH-1:0] Out_C,
  output logic [WIDTH-1:0] Out_D,
  output logic [3:0]       Out_Valid,
  input  logic [3:0]       Out_Ready,
  output logic [CNT_W-1:0] Xfer_Cnt
`ifdef DEMUX_AUTO_SEQ_EN
  ,
  output logic [1:0]       Seq_Ptr
`endif
);

  localparam int NUM_CH = 4;

  logic [1:0]                  w_dsel;
  logic                        w_in_ready;
  logic                        w_acc;
  logic [NUM_CH-1:0]           w_load;
  logic [NUM_CH-1:0]           w_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] w_out;
  logic [CNT_W-1:0]            r_cnt;

  // -------------------------------------------------------------------------
  // Destination select
  // -------------------------------------------------------------------------
`ifdef DEMUX_AUTO_SEQ_EN
  logic [1:0] r_seq_ptr;

  // Advances only on an accepted word; a blocked channel therefore
  // holds the pointer and stalls the stream. Natural 2-bit wrap 3->0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     r_seq_ptr <= 2'd0;
    else if (w_acc) r_seq_ptr <= r_seq_ptr + 2'd1;
  end

  assign w_dsel  = r_seq_ptr;
  assign Seq_Ptr = r_seq_ptr;
`else
  assign w_dsel = Sel;
`endif

  // -------------------------------------------------------------------------
  // Input handshake
  // -------------------------------------------------------------------------
  // Ready depends only on the chosen channel's state, never on In_Valid.
  // Gating with Rst_n keeps the producer from seeing ready while the
  // block is held in reset.
  assign w_in_ready = Rst_n & (~w_valid[w_dsel] | Out_Ready[w_dsel]);
  assign w_acc      = In_Valid & w_in_ready;
  assign In_Ready   = w_in_ready;

  // -------------------------------------------------------------------------
  // Output channels
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = w_acc & (w_dsel == 2'(g));

    demux_1to4_buf_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .i_load  (w_load[g]),
      .i_data  (In_Data),
      .i_ready (Out_Ready[g]),
      .o_data  (w_out[g]),
      .o_valid (w_valid[g])
    );
  end

  assign Out_A     = w_out[0];
  assign Out_B     = w_out[1];
  assign Out_C     = w_out[2];
  assign Out_D     = w_out[3];
  assign Out_Valid = w_valid;

  // -------------------------------------------------------------------------
  // Accepted-transfer counter (free-running wrap)
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     r_cnt <= '0;
    else if (w_acc) r_cnt <= r_cnt + 1'b1;
  end

  assign Xfer_Cnt = r_cnt;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// ---------------------------------------------------------------------------
// tb_demux_1to4_buf
//
// Reference model: each output channel is a queue of words accepted for it
// that the consumer has not yet taken. The stimulus side pushes a word when
// the model says it was accepted; a separate monitor pops a word whenever a
// channel handshakes and compares it with the DUT output. Channel valid is
// "queue not empty", and the transfer count is the number of accepts
// modulo 2^16.
// ---------------------------------------------------------------------------
module tb_demux_1to4_buf;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [1:0]  Sel;
  logic [7:0]  Out_A, Out_B, Out_C, Out_D;
  logic [3:0]  Out_Valid;
  logic [3:0]  Out_Ready;
  logic [15:0] Xfer_Cnt;
`ifdef DEMUX_AUTO_SEQ_EN
  logic [1:0]  Seq_Ptr;
`endif

  demux_1to4_buf #(.WIDTH(8), .CNT_W(16)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Sel       (Sel),
    .Out_A     (Out_A),
    .Out_B     (Out_B),
    .Out_C     (Out_C),
    .Out_D     (Out_D),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Xfer_Cnt  (Xfer_Cnt)
`ifdef DEMUX_AUTO_SEQ_EN
    ,
    .Seq_Ptr   (Seq_Ptr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef logic [7:0] wq_t[$];
  wq_t         q [4];
  logic [7:0]  last [4];
  logic [15:0] m_cnt;
  logic [1:0]  m_ptr;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [3:0][7:0] outs;
  assign outs = {Out_D, Out_C, Out_B, Out_A};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      last[i] = 8'h00;
    end
    m_cnt = 16'd0;
    m_ptr = 2'd0;
  endtask

  // Monitor: checks every channel at mid-cycle and consumes model words on
  // handshakes.
  always @(negedge Clk) begin
    if (Rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid[%0d]", i), {31'd0, Out_Valid[i]}, {31'd0, q[i].size() != 0});
        chk($sformatf("held[%0d]", i), {24'd0, outs[i]}, {24'd0, last[i]});
        if (Out_Valid[i] && Out_Ready[i] && q[i].size() != 0) begin
          logic [7:0] w;
          w = q[i].pop_front();
          chk($sformatf("pop[%0d]", i), {24'd0, outs[i]}, {24'd0, w});
        end
      end
      chk("xfer_cnt", {16'd0, Xfer_Cnt}, {16'd0, m_cnt});
`ifdef DEMUX_AUTO_SEQ_EN
      chk("seq_ptr", {30'd0, Seq_Ptr}, {30'd0, m_ptr});
`endif
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d,
                     input logic [3:0] r, output logic acc);
    logic [1:0] ds;
    logic       exp_rdy;
    In_Valid = v; Sel = s; In_Data = d; Out_Ready = r;
    @(negedge Clk); #1;
    ds = s;
`ifdef DEMUX_AUTO_SEQ_EN
    ds = m_ptr;
`endif
    exp_rdy = (q[ds].size() == 0) || r[ds];
    chk("in_ready", {31'd0, In_Ready}, {31'd0, exp_rdy});
    acc = v && In_Ready;
    if (acc) begin
      q[ds].push_back(d);
      last[ds] = d;
      m_cnt = m_cnt + 16'd1;
      m_ptr = m_ptr + 2'd1;
    end
    @(posedge Clk); #1;
  endtask

  // Offer a word until accepted, bounded.
  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cyc(1'b1, s, d, r, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic [3:0] r, input int n);
    logic acc;
    for (int k = 0; k < n; k++) cyc(1'b0, 2'd0, 8'h00, r, acc);
  endtask

  initial begin
    logic       acc;
    logic       pv;
    logic [1:0] ps;
    logic [7:0] pd;
    int         guard;

    Rst_n = 1'b0; In_Valid = 1'b0; Sel = 2'd0; In_Data = 8'h00; Out_Ready = 4'h0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    In_Valid = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("rst_valid", {28'd0, Out_Valid}, 32'd0);
    chk("rst_cnt", {16'd0, Xfer_Cnt}, 32'd0);
    chk("rst_outs", outs, 32'd0);
    In_Valid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;

`ifndef DEMUX_AUTO_SEQ_EN
    // Single word into C, then C full blocks the next word.
    send(2'd2, 8'h5A, 4'h0);
    chk("t1_outc", {24'd0, Out_C}, 32'h5A);
    chk("t1_valid", {28'd0, Out_Valid}, 32'h4);
    chk("t1_cnt", {16'd0, Xfer_Cnt}, 32'd1);
    cyc(1'b1, 2'd2, 8'h77, 4'h0, acc);
    chk("t1_blocked", {31'd0, acc}, 32'd0);
    idle(4'hF, 2);

    // Fill A..D, then drain A and C only.
    send(2'd0, 8'h01, 4'h0);
    send(2'd1, 8'h02, 4'h0);
    send(2'd2, 8'h03, 4'h0);
    send(2'd3, 8'h04, 4'h0);
    chk("t3_full", {28'd0, Out_Valid}, 32'hF);
    idle(4'b0101, 1);
    chk("t3_valid", {28'd0, Out_Valid}, 32'hA);
    chk("t3_outb", {24'd0, Out_B}, 32'h02);
    chk("t3_outd", {24'd0, Out_D}, 32'h04);
    idle(4'hF, 2);

    // Pass-through into a full B being drained.
    send(2'd1, 8'h11, 4'h0);
    cyc(1'b1, 2'd1, 8'h22, 4'b0010, acc);
    chk("t2_acc", {31'd0, acc}, 32'd1);
    chk("t2_outb", {24'd0, Out_B}, 32'h22);
    chk("t2_valid1", {31'd0, Out_Valid[1]}, 32'd1);
    idle(4'hF, 2);

    // Asynchronous reset with A, B, D full.
    send(2'd0, 8'hA1, 4'h0);
    send(2'd1, 8'hB1, 4'h0);
    send(2'd3, 8'hD1, 4'h0);
    chk("t4_pre", {28'd0, Out_Valid}, 32'hB);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t4_valid", {28'd0, Out_Valid}, 32'd0);
    chk("t4_outs", outs, 32'd0);
    chk("t4_cnt", {16'd0, Xfer_Cnt}, 32'd0);
    chk("t4_in_ready", {31'd0, In_Ready}, 32'd0);
    model_reset();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    send(2'd3, 8'h3C, 4'h0);
    chk("t4_cnt1", {16'd0, Xfer_Cnt}, 32'd1);
    idle(4'hF, 2);
`else
    // Rotating destinations regardless of Sel.
    for (int k = 0; k < 5; k++) send(2'd3, 8'(8'h10 + k), 4'hF);
    chk("seq_end", {30'd0, Seq_Ptr}, 32'd1);
    idle(4'hF, 3);
`endif

    // Randomized traffic; the producer holds its word until accepted.
    pv = 1'b0; ps = 2'd0; pd = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 2'($urandom_range(0, 3));
        pd = 8'($urandom);
      end
      cyc(pv, ps, pd, 4'($urandom), acc);
      if (acc) pv = 1'b0;
    end
    idle(4'hF, 2);

    // Counter wrap: run up to 0xFFFF, then one more accept.
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cyc(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 4'hF, acc);
      guard++;
    end
    chk("wrap_pre", {16'd0, Xfer_Cnt}, 32'hFFFF);
    send(2'd0, 8'hEE, 4'hF);
    chk("wrap_zero", {16'd0, Xfer_Cnt}, 32'd0);
    idle(4'hF, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to4_buf.md
Name: demux_1to4_buf

Overview:
- 1-to-4 demultiplexer: the distribution-side counterpart of the 4-to-1 mux.
- Routes a valid/ready input stream to one of four output channels, chosen by Sel.
- Each output channel has a one-entry holding register with its own valid/ready handshake, so downstream consumers can stall independently.
- Sits between a shared producer (e.g. a mux/arbiter output) and four per-channel consumers.

Parameters:
- WIDTH, 8, data width of the input and of each output channel.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- In_Data  input  WIDTH  input payload.
- In_Valid  input  1  input payload valid.
- In_Ready  output  1  block can accept In_Data this cycle.
- Sel  input  2  destination channel: 00=A, 01=B, 10=C, 11=D.
- Out_A  output  WIDTH  channel A holding register.
- Out_B  output  WIDTH  channel B holding register.
- Out_C  output  WIDTH  channel C holding register.
- Out_D  output  WIDTH  channel D holding register.
- Out_Valid  output  4  per-channel valid; bit0=A … bit3=D.
- Out_Ready  input  4  per-channel consumer ready; same bit order.
- Xfer_Cnt  output  CNT_W  count of accepted input transfers.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - Out_A..Out_D = 0, Out_Valid = 4'b0000, Xfer_Cnt = 0.
  - In_Ready forced 0 while Rst_n is low.
  - Any held data is discarded; no transfer completes in the cycle Rst_n deasserts.
- Destination: the effective select is dsel = Sel (see Optional Feature).
- In_Ready (combinational) = Rst_n & (~Out_Valid[dsel] | Out_Ready[dsel]).
  - Accepts into an empty channel.
  - Accepts into a full channel being drained in the same cycle (pass-through, no bubble).
  - In_Ready may depend on In_Valid's channel choice; it never depends on In_Valid itself.
- Accept: acc = In_Valid & In_Ready. On a Clk edge with acc:
  - Out_<dsel> <= In_Data.
  - Out_Valid[dsel] <= 1.
  - Xfer_Cnt <= Xfer_Cnt + 1, wrapping from 2^CNT_W-1 to 0.
- Pop: pop[i] = Out_Valid[i] & Out_Ready[i].
  - On an edge with pop[i] and no acc to channel i: Out_Valid[i] <= 0.
  - Out_<i> data is held unchanged.
- Simultaneous acc and pop on the same channel: valid stays 1 and data takes the new In_Data.
- Simultaneous acc on one channel and pops on other channels: each channel updates independently.
- Latency: In_Data appears on Out_<dsel> with Out_Valid set one Clk after acceptance.
- Full channel, no Out_Ready: In_Ready = 0. The producer must hold In_Data, In_Valid and Sel stable until acceptance.
- Out_Ready asserted on an empty channel: no effect.
- A channel's data register changes only on acceptance into that channel.
- Throughput: one transfer per cycle when the destination drains.

Optional Feature:
- Macro: DEMUX_AUTO_SEQ_EN.
- Defined:
  - Sel is ignored.
  - An internal 2-bit round-robin pointer Seq_Ptr (reset 0) is dsel.
  - Seq_Ptr increments on each acc and wraps 3 -> 0.
  - Seq_Ptr holds while the target channel is full. No skipping: a blocked channel stalls the stream.
  - Extra output port Seq_Ptr (output, 2 bits) is present.
- Undefined: dsel = Sel, and no Seq_Ptr register or port exists.

Test Plan:
- Reset, then In_Valid=1, Sel=2'b10, In_Data=8'h5A, Out_Ready=4'b0000 -> one cycle later: Out_C=8'h5A, Out_Valid=4'b0100, Xfer_Cnt=1. Next cycle with Sel=10 still valid: In_Ready=0.
- Channel B full (8'h11), Out_Ready[1]=1, In_Valid=1, Sel=01, In_Data=8'h22 -> In_Ready=1 that cycle; next cycle Out_B=8'h22, Out_Valid[1]=1 (no bubble).
- Fill A..D with 01,02,03,04 back-to-back, Out_Ready=0 -> Out_Valid=4'b1111 after 4 cycles. Then set Out_Ready=4'b0101 for one cycle -> Out_Valid=4'b1010, Out_B=02 and Out_D=04 unchanged.
- Assert Rst_n=0 mid-stream with Out_Valid=4'b1011 and no Clk edge -> outputs immediately 0, In_Ready=0. After release, the first accept sets Xfer_Cnt=1.
- Preload Xfer_Cnt via 65535 accepts (CNT_W=16), then one more accept -> Xfer_Cnt=0.
- With DEMUX_AUTO_SEQ_EN defined: send 5 words with Sel tied to 11, Out_Ready=4'b1111 -> words land on A,B,C,D,A and Seq_Ptr ends at 1. With Out_Ready[0]=0 and A full, the 5th word stalls (In_Ready=0, Seq_Ptr=0).
